// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the counter sequence checker: FSM state encodings.
package count_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_TRACK = 2'b10,
    ST_ERROR = 2'b11
  } chk_state_t;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= sat_inc(q);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running up-counter: q must step +1 while enabled and sit at 0 while
// disabled. Reports lock state, wrap events and sequence errors.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic [WIDTH-1:0]  q,
  input  logic              clr,
  output logic [1:0]        state,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  chk_state_t       cur, nxt;
  logic [WIDTH-1:0] q_prev;
  logic             idle_first;
  logic             err_d;
  logic             wrap_d;

  always_comb begin
    nxt    = cur;
    err_d  = 1'b0;
    wrap_d = 1'b0;
    unique case (cur)
      ST_IDLE: begin
        // The counter clears on the edge we enter IDLE, so skip the first look.
        if (!idle_first && (q != '0)) begin
          err_d = 1'b1;
        end else if (cnt_en) begin
          nxt = ST_SYNC;
        end
      end
      ST_SYNC: nxt = cnt_en ? ST_TRACK : ST_IDLE;
      ST_TRACK: begin
        if (!cnt_en) begin
          nxt = ST_IDLE;
        end else if (q == q_prev + WIDTH'(1)) begin
          wrap_d = &q_prev;
        end else begin
          err_d = 1'b1;
          nxt   = ST_ERROR;
        end
      end
      ST_ERROR: nxt = cnt_en ? ST_SYNC : ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= ST_IDLE;
      idle_first <= 1'b1;
      q_prev     <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      cur        <= nxt;
      idle_first <= (nxt == ST_IDLE) && (cur != ST_IDLE);
      q_prev     <= q;
      locked     <= (nxt == ST_TRACK);
      err        <= err_d;
      wrap_pulse <= wrap_d;
      wrap_cnt   <= clr ? '0 : wrap_cnt + WRAP_W'(wrap_d);
    end
  end

  assign state = cur;

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_d),
    .q   (err_cnt)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed and randomized bench for count_seq_checker with an abstract reference model.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_en = 1'b0;
  logic [3:0] q = 4'd0;
  logic       clr = 1'b0;
  logic [1:0] state;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [3:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 sync, 2 track, 3 error
  int m_st, m_first, m_qprev, m_wraps, m_errs;
  bit e_err, e_wrap, e_lock;
  int ctr = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_en     (cnt_en),
    .q          (q),
    .clr        (clr),
    .state      (state),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model(input bit en, input bit c, input bit r, input int qv);
    int ns;
    bit e, w;
    if (r) begin
      m_st = 0; m_first = 1; m_qprev = 0; m_wraps = 0; m_errs = 0;
      e_err = 0; e_wrap = 0; e_lock = 0;
      return;
    end
    e = 0; w = 0; ns = m_st;
    if (m_st == 0) begin
      if (m_first == 0 && qv != 0) e = 1;
      else ns = en ? 1 : 0;
    end else if (m_st == 1) begin
      ns = en ? 2 : 0;
    end else if (m_st == 2) begin
      if (!en) ns = 0;
      else if (qv == (m_qprev + 1) % 16) w = (m_qprev == 15);
      else begin e = 1; ns = 3; end
    end else begin
      ns = en ? 1 : 0;
    end
    m_first = (ns == 0 && m_st != 0) ? 1 : 0;
    m_st    = ns;
    m_qprev = qv;
    m_wraps = c ? 0 : m_wraps + int'(w);
    m_errs  = c ? 0 : m_errs + int'(e);
    e_err = e; e_wrap = w; e_lock = (ns == 2);
  endtask

  task automatic step(input bit en, input bit c, input bit r, input bit fz, input int fv);
    int qv;
    @(negedge clk);
    qv = fz ? (fv % 16) : ctr;
    cnt_en = en; clr = c; rst = r; q = 4'(qv);
    @(posedge clk);
    model(en, c, r, qv);
    ctr = (r || !en) ? 0 : (ctr + 1) % 16;
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("locked", 32'(locked), 32'(e_lock));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
    chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wraps % 256));
    chk("err", 32'(err), 32'(e_err));
    chk("err_cnt", 32'(err_cnt), 32'((m_errs > 15) ? 15 : m_errs));
  endtask

  // enabled steps until q=target has just been accepted in TRACK
  task automatic go_to(input int target);
    int g = 0;
    while (!(m_st == 2 && m_qprev == target) && g < 64) begin
      step(1, 0, 0, 0, 0);
      g++;
    end
    chk("go_to_bound", 32'(g < 64), 32'd1);
  endtask

  task automatic run_wraps(input int n);
    int seen = 0;
    int g = 0;
    while (seen < n && g < n * 16 + 40) begin
      step(1, 0, 0, 0, 0);
      if (wrap_pulse === 1'b1) seen++;
      g++;
    end
    chk("wrap_bound", 32'(seen), 32'(n));
  endtask

  initial begin
    int cnt, g;
    bit lock3;

    // reset
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);

    // free run from 0 for 40 edges
    cnt = 0; lock3 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0, 0);
      if (wrap_pulse === 1'b1) cnt++;
      if (i == 2) lock3 = locked;
    end
    chk("t2_wraps", 32'(cnt), 32'd2);
    chk("t2_lock3", 32'(lock3), 32'd1);
    chk("t2_wrap_cnt", 32'(wrap_cnt), 32'd2);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // single skip 5 -> 7
    go_to(5);
    step(1, 0, 0, 1, 7);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_st_err", 32'(state), 32'd3);
    step(1, 0, 0, 0, 0);
    chk("t3_st_sync", 32'(state), 32'd1);
    step(1, 0, 0, 0, 0);
    chk("t3_st_track", 32'(state), 32'd2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      if (err === 1'b1) cnt++;
    end
    chk("t3_no_more_err", 32'(cnt), 32'd0);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);

    // 20 injected errors saturate err_cnt
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      g = 0;
      while (m_st != 2 && g < 10) begin
        step(1, 0, 0, 0, 0);
        g++;
      end
      chk("t4_bound", 32'(g < 10), 32'd1);
      step(1, 0, 0, 1, ctr + 3);
      if (err === 1'b1) cnt++;
    end
    chk("t4_pulses", 32'(cnt), 32'd20);
    chk("t4_sat", 32'(err_cnt), 32'd15);

    // drop enable in TRACK, then stuck nonzero q in IDLE
    step(1, 1, 0, 0, 0);
    go_to(9);
    cnt = 0;
    step(0, 0, 0, 0, 0);
    if (err === 1'b1) cnt++;
    chk("t5_idle", 32'(state), 32'd0);
    step(0, 0, 0, 1, 3);
    if (err === 1'b1) cnt++;
    step(0, 0, 0, 1, 3);
    chk("t5_err_second", 32'(err), 32'd1);
    if (err === 1'b1) cnt++;
    chk("t5_err_once", 32'(cnt), 32'd1);
    chk("t5_err_cnt", 32'(err_cnt), 32'd1);

    // clr on a wrap, then wrap counter rollover
    step(0, 1, 0, 0, 0);
    run_wraps(5);
    chk("t6_wrap5", 32'(wrap_cnt), 32'd5);
    g = 0;
    while (ctr != 0 && g < 20) begin
      step(1, 0, 0, 0, 0);
      g++;
    end
    chk("t6_bound", 32'(g < 20), 32'd1);
    step(1, 1, 0, 0, 0);
    chk("t6_clr_pulse", 32'(wrap_pulse), 32'd1);
    chk("t6_clr_cnt", 32'(wrap_cnt), 32'd0);
    run_wraps(255);
    chk("t6_wrap255", 32'(wrap_cnt), 32'd255);
    run_wraps(1);
    chk("t6_rollover", 32'(wrap_cnt), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) != 0, ($urandom % 32) == 0, ($urandom % 64) == 0,
           ($urandom % 6) == 0, int'($urandom % 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
